// File: rtl/morse_receiver.sv
// Morse receiver for letters A-H: synchronizes the key, times marks/spaces in
// TICK_COUNT units and decodes the symbol buffer. Define MORSE_HEX_EN for HEX0 segment output.
module morse_receiver #(
  parameter int TICK_COUNT = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       error,
  output logic [6:0] HEX0
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  localparam logic [26:0] DIV_LAST = 27'(TICK_COUNT - 1);

  logic        sync1_q, sync2_q, key_prev_q;
  state_t      state_q, state_d;
  logic [26:0] div_q, div_d;
  logic [2:0]  run_q, run_d;
  logic [3:0]  sym_q, sym_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  letter_q, letter_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        key_rise, key_fall, key_edge, tick;
  logic        dec_hit;
  logic [2:0]  dec_idx;

  assign key_rise = sync2_q & ~key_prev_q;
  assign key_fall = ~sync2_q & key_prev_q;
  assign key_edge = key_rise | key_fall;
  // An edge restarts timing, so a coincident tick is dropped.
  assign tick = (state_q != IDLE) && !key_edge && (div_q == DIV_LAST);

  // Buffer is left-shifted, so the first symbol sits at bit cnt-1.
  always_comb begin
    dec_hit = 1'b1;
    dec_idx = 3'd0;
    case ({cnt_q, sym_q})
      {3'd2, 4'b0001}: dec_idx = 3'd0;
      {3'd4, 4'b1000}: dec_idx = 3'd1;
      {3'd4, 4'b1010}: dec_idx = 3'd2;
      {3'd3, 4'b0100}: dec_idx = 3'd3;
      {3'd1, 4'b0000}: dec_idx = 3'd4;
      {3'd4, 4'b0010}: dec_idx = 3'd5;
      {3'd3, 4'b0110}: dec_idx = 3'd6;
      {3'd4, 4'b0000}: dec_idx = 3'd7;
      default:         dec_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    run_d    = run_q;
    sym_d    = sym_q;
    cnt_d    = cnt_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (state_q == IDLE || key_edge) begin
      div_d = '0;
      run_d = '0;
    end else if (tick) begin
      div_d = '0;
      run_d = (run_q == 3'd7) ? 3'd7 : run_q + 3'd1;
    end else begin
      div_d = div_q + 27'd1;
    end

    case (state_q)
      IDLE: begin
        if (key_rise) state_d = MARK;
      end
      MARK: begin
        if (key_fall) begin
          if (run_q >= 3'd5 || cnt_q == 3'd4) begin
            err_d   = 1'b1;
            sym_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            sym_d   = {sym_q[2:0], (run_q >= 3'd2)};
            cnt_d   = cnt_q + 3'd1;
            state_d = SPACE;
          end
        end
      end
      SPACE: begin
        if (key_rise) begin
          state_d = MARK;
        end else if (tick && run_q == 3'd1) begin
          if (dec_hit) begin
            letter_d = dec_idx;
            valid_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          sym_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      key_prev_q <= 1'b0;
      state_q    <= IDLE;
      div_q      <= '0;
      run_q      <= '0;
      sym_q      <= '0;
      cnt_q      <= '0;
      letter_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= key_in;
      sync2_q    <= sync1_q;
      key_prev_q <= sync2_q;
      state_q    <= state_d;
      div_q      <= div_d;
      run_q      <= run_d;
      sym_q      <= sym_d;
      cnt_q      <= cnt_d;
      letter_q   <= letter_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = valid_q;
  assign error        = err_q;

`ifdef MORSE_HEX_EN
  logic       shown_q, shown_d;
  logic [6:0] seg;

  assign shown_d = shown_q | valid_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) shown_q <= 1'b0;
    else       shown_q <= shown_d;
  end

  always_comb begin
    seg = 7'h7F;
    case (letter_q)
      3'd0: seg = 7'h08;
      3'd1: seg = 7'h03;
      3'd2: seg = 7'h46;
      3'd3: seg = 7'h21;
      3'd4: seg = 7'h06;
      3'd5: seg = 7'h0E;
      3'd6: seg = 7'h42;
      3'd7: seg = 7'h09;
      default: seg = 7'h7F;
    endcase
  end

  assign HEX0 = shown_q ? seg : 7'h7F;
`else
  assign HEX0 = '1;
`endif

endmodule

// File: doc/morse_receiver.md
MORSE_RECEIVER -- requirements
Module: morse_receiver

Interface
REQ-001 Parameter: TICK_COUNT, 25000000, clock cycles per Morse time unit (0.5 s at 50 MHz); legal range 2..2^27-1.
REQ-002 Port: CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: key_in  input  1  Morse key, high = tone, asynchronous to CLOCK_50.
REQ-005 Port: letter  output  3  index of last decoded letter, 0=A through 7=H.
REQ-006 Port: letter_valid  output  1  one-cycle pulse when letter is updated.
REQ-007 Port: error  output  1  one-cycle pulse when a received pattern is rejected.
REQ-008 Port: HEX0  output  7  active-low 7-segment display of letter, segment 0 = bit 0.

Function
REQ-009 key_in SHALL pass through a two-flop synchronizer; all edges below refer to the synchronized key, detected one cycle after the second flop.
REQ-010 A 27-bit divider SHALL count CLOCK_50 cycles; it SHALL clear on every key edge and emit a one-cycle tick every TICK_COUNT cycles thereafter.
REQ-011 A 3-bit run counter SHALL clear on every key edge, increment on each tick, and saturate at 7.
REQ-012 States: IDLE (key low, no symbols held), MARK (key high), SPACE (key low, 1-4 symbols held).
REQ-013 IDLE -> MARK on rising edge; divider, run counter and symbol buffer stay clear in IDLE.
REQ-014 MARK -> SPACE on falling edge; run<2 appends dot (0), run 2..4 appends dash (1), run>=5 rejects the letter.
REQ-015 Symbols SHALL shift into a 4-bit buffer in arrival order, first symbol in the MSB, with a 3-bit count.
REQ-016 Appending a 5th symbol SHALL reject the letter.
REQ-017 SPACE -> MARK on rising edge before run reaches 2; the buffer is kept.
REQ-018 SPACE with run reaching 2 (letter end) SHALL decode the buffer and return to IDLE.
REQ-019 Decode table: A .-, B -..., C -.-., D -.., E ., F ..-., G --., H ....
REQ-020 A match SHALL load letter and pulse letter_valid on the cycle after the letter-end tick.
REQ-021 A non-match SHALL pulse error instead, leaving letter unchanged.
REQ-022 Reject: pulse error, clear buffer, enter IDLE if key low; if key high, stay in MARK and ignore symbols until the next falling edge, then enter IDLE.
REQ-023 A key edge and a tick in the same cycle: edge wins, tick discarded.
REQ-024 letter_valid and error SHALL never be high in the same cycle.

Reset
REQ-025 Reset SHALL force IDLE, clear synchronizer, divider, run counter and symbol buffer, and set letter=0, letter_valid=0, error=0.
REQ-026 Reset mid-letter SHALL discard partial symbols with no pulse.
REQ-027 HEX0 after reset SHALL be 7'h7F (blank) until the first letter_valid.

Configuration
REQ-028 Macro MORSE_HEX_EN defined: HEX0 shows A, b, C, d, E, F, G, H for letter 0-7 after the first valid letter.
REQ-029 Macro MORSE_HEX_EN undefined: HEX0 SHALL be constant 7'h7F and no segment logic is built.

Verification (TICK_COUNT=4)
REQ-030 Key high 4 cycles, low 16 -> letter=4 (E), one letter_valid pulse, error=0.
REQ-031 Dot, gap 4, dash 12, low 16 -> letter=0 (A); with MORSE_HEX_EN, HEX0=A pattern.
REQ-032 Four dashes with 4-cycle gaps, then low 16 -> error pulse, letter unchanged.
REQ-033 Key high 24 cycles, low 16 -> error pulse on the falling edge, no letter_valid.
REQ-034 Two dots, reset asserted during the gap, then low 16 -> no pulses, letter=0, HEX0=7'h7F.
REQ-035 Five dots with 4-cycle gaps -> error pulse on the 5th falling edge, IDLE afterwards.
